// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants and types for the median window scan controller
package median_pkg;

    localparam int IMG_DIM   = 64;
    localparam int WIN       = 3;
    localparam int ADDR_W    = $clog2(IMG_DIM);
    localparam int SCAN_DIM  = IMG_DIM - WIN + 1;
    localparam int WIN_COUNT = SCAN_DIM * SCAN_DIM;
    localparam int CNT_W     = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]        data;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
    } res_entry_t;

endpackage

// File: rtl/median_res_fifo.sv
// rtl/median_res_fifo.sv - small show-ahead synchronous FIFO for filtered results
module median_res_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is refused even when a pop happens in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; reset empties the queue and clears the entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/median_scan_ctrl.sv
// rtl/median_scan_ctrl.sv - raster window scan with prioritised result write-back
module median_scan_ctrl #(
    parameter int IMG_DIM        = 64,
    parameter int WIN            = 3,
    parameter int RES_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       memread,
    output logic       memwrite,
    output logic [5:0] address_row,
    output logic [5:0] address_col,
    output logic [7:0] DIN,
    output logic       win_valid,
    input  logic       win_ready,
    output logic [5:0] win_row,
    output logic [5:0] win_col,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [7:0] res_data,
    input  logic [5:0] res_row,
    input  logic [5:0] res_col
);

    import median_pkg::*;

    localparam logic [5:0]  LAST_POS = 6'(IMG_DIM - WIN);
    localparam logic [11:0] TOTAL    = 12'((IMG_DIM - WIN + 1) * (IMG_DIM - WIN + 1));

    state_t      state;
    state_t      state_next;
    logic [5:0]  scan_row;
    logic [5:0]  scan_col;
    logic [11:0] wr_cnt;
    logic [11:0] wr_cnt_inc;
    logic [5:0]  hold_row;
    logic [5:0]  hold_col;
    logic [7:0]  hold_din;
    logic        wr_slot;
    logic        rd_slot;
    logic        last_read;
    logic        frame_start;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    res_entry_t  push_entry;
    res_entry_t  head;

    assign push_entry  = '{data: res_data, row: res_row, col: res_col};
    assign push        = res_valid && res_ready;
    assign res_ready   = !fifo_full;
    assign frame_start = (state == IDLE) && start;

    median_res_fifo #(
        .DEPTH (RES_FIFO_DEPTH),
        .T     (res_entry_t)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (wr_slot),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Slot arbitration: pending write-back wins, a read only when no window is outstanding.
    always_comb begin
        wr_slot    = !fifo_empty;
        rd_slot    = !wr_slot && (state == SCAN) && !win_valid;
        last_read  = rd_slot && (scan_row == LAST_POS) && (scan_col == LAST_POS);
        wr_cnt_inc = wr_cnt + 12'(wr_slot);
    end

    // Shared address/data bus; it keeps its last driven value during idle slots.
    always_comb begin
        memread     = rd_slot;
        memwrite    = wr_slot;
        address_row = hold_row;
        address_col = hold_col;
        DIN         = hold_din;
        if (wr_slot) begin
            address_row = head.row;
            address_col = head.col;
            DIN         = head.data;
        end else if (rd_slot) begin
            address_row = scan_row;
            address_col = scan_col;
        end
    end

    // Next-state logic and state-derived status outputs.
    always_comb begin
        state_next = state;
        busy       = (state == SCAN) || (state == DRAIN);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last_read) state_next = DRAIN;
            DRAIN:   if (wr_cnt_inc >= TOTAL) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scan position (column fastest) and written count, both cleared when a frame begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_row <= '0;
            scan_col <= '0;
            wr_cnt   <= '0;
        end else begin
            if (frame_start) begin
                scan_row <= '0;
                scan_col <= '0;
            end else if (rd_slot) begin
                if (scan_col == LAST_POS) begin
                    scan_col <= '0;
                    scan_row <= scan_row + 6'd1;
                end else begin
                    scan_col <= scan_col + 6'd1;
                end
            end
            if (frame_start) begin
                wr_cnt <= '0;
            end else if (wr_slot) begin
                wr_cnt <= wr_cnt_inc;
            end
        end
    end

    // Window presented downstream one cycle after its read, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (rd_slot) begin
            win_valid <= 1'b1;
            win_row   <= scan_row;
            win_col   <= scan_col;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    // Remember the last driven bus values so idle slots do not disturb the memory inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_row <= '0;
            hold_col <= '0;
            hold_din <= '0;
        end else if (wr_slot || rd_slot) begin
            hold_row <= address_row;
            hold_col <= address_col;
            hold_din <= DIN;
        end
    end

endmodule

// File: tb/tb_median_scan_ctrl.sv
// tb/tb_median_scan_ctrl.sv - directed self-checking bench for median_scan_ctrl
module tb_median_scan_ctrl;
    import median_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, memread, memwrite;
    logic [5:0] address_row, address_col;
    logic [7:0] DIN;
    logic       win_valid;
    logic       win_ready = 1'b1;
    logic [5:0] win_row, win_col;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [7:0] res_data = '0;
    logic [5:0] res_row = '0;
    logic [5:0] res_col = '0;

    logic       f_push = 1'b0;
    logic       f_pop = 1'b0;
    logic [7:0] f_din = '0;
    logic [7:0] f_head;
    logic       f_full, f_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    median_scan_ctrl #(.IMG_DIM(64), .WIN(3), .RES_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .memread(memread), .memwrite(memwrite),
        .address_row(address_row), .address_col(address_col), .DIN(DIN),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
    );

    median_res_fifo #(.DEPTH(4), .T(logic [7:0])) u_fifo (
        .clk(clk), .rst(rst), .push(f_push), .push_data(f_din), .pop(f_pop),
        .head(f_head), .full(f_full), .empty(f_empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        rst = 1'b0;
        step;
    endtask

    task automatic wait_read(input int r, input int c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            if (memread && address_row == 6'(r) && address_col == 6'(c)) ok = 1'b1;
            else step;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, last_rd, er, ec, bad;
        int rd_n, wr_n, done_n, bad_rd, bad_wr, fin, p, r, c, d, e;
        bit busy_prev, kicked;
        int pend_q[$];
        int exp_q[$];

        // reset state
        #2 rst = 1'b1;
        step;
        chk("rst_outputs", {memread, memwrite, win_valid, busy, done, win_row, win_col,
                            address_row, address_col, DIN}, 0);
        rst = 1'b0;
        step;
        chk("rst_res_ready", res_ready, 1);
        chk("rst_state", dut.state, IDLE);

        // queue occupancy: full at 4, push+pop on full refused, order kept
        for (int k = 0; k < 4; k++) begin
            if (k == 3) chk("fifo_not_full_at_3", f_full, 0);
            f_push = 1'b1;
            f_din = 8'(17 * (k + 1));
            step;
        end
        f_push = 1'b0;
        chk("fifo_full_at_4", f_full, 1);
        f_push = 1'b1; f_din = 8'h55; f_pop = 1'b1;
        step;
        f_push = 1'b0; f_pop = 1'b0;
        chk("fifo_reopen", f_full, 0);
        for (int k = 1; k < 4; k++) begin
            chk("fifo_order", f_head, 8'(17 * (k + 1)));
            f_pop = 1'b1;
            step;
        end
        f_pop = 1'b0;
        chk("fifo_empty", f_empty, 1);

        // frame A: no results, win_ready tied high
        start = 1'b1; step; start = 1'b0;
        n = 0; last_rd = -100; er = 0; ec = 0; bad = 0;
        for (int cyc = 0; cyc < 10000 && n < 3844; cyc++) begin
            if (memread) begin
                if (n == 0) chk("first_read", {address_row, address_col}, 12'h000);
                if (n == 1) chk("read_gap", cyc - last_rd, 2);
                if (n == 62) chk("read_63", {address_row, address_col}, {6'd1, 6'd0});
                if (n == 3843) chk("last_read", {address_row, address_col}, {6'd61, 6'd61});
                if (address_row != 6'(er) || address_col != 6'(ec)) bad++;
                if (ec == 61) begin ec = 0; er++; end else ec++;
                last_rd = cyc;
                n++;
            end
            step;
            if (n == 1 && cyc == last_rd)
                chk("win_after_read", {win_valid, win_row, win_col}, {1'b1, 12'h000});
        end
        chk("frame_a_reads", n, 3844);
        chk("frame_a_seq", bad, 0);
        chk("enter_drain", dut.state, DRAIN);
        chk("drain_busy", busy, 1);
        do_reset;

        // frame B: back-pressure, write priority, burst of results, reset mid-scan
        start = 1'b1; step; start = 1'b0;
        wait_read(0, 3, ok);
        chk("find_0_3", ok, 1);
        win_ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step;
            if ({win_valid, win_row, win_col, memread} != {1'b1, 6'd0, 6'd3, 1'b0}) bad++;
        end
        chk("hold_window", bad, 0);
        win_ready = 1'b1;
        step;
        chk("read_after_hs", {memread, address_row, address_col}, {1'b1, 6'd0, 6'd4});
        step;
        chk("win_0_4", {win_valid, win_row, win_col}, {1'b1, 6'd0, 6'd4});
        res_valid = 1'b1; res_data = 8'hA5; res_row = 6'd2; res_col = 6'd7;
        step;
        res_valid = 1'b0;
        chk("write_slot", {memwrite, memread, address_row, address_col, DIN},
            {1'b1, 1'b0, 6'd2, 6'd7, 8'hA5});
        step;
        chk("read_follows", {memread, address_row, address_col}, {1'b1, 6'd0, 6'd5});
        step;
        chk("bus_hold", {memread, memwrite, address_row, address_col, DIN},
            {1'b0, 1'b0, 6'd0, 6'd5, 8'hA5});
        for (int k = 0; k < 4; k++) begin
            chk("burst_ready", res_ready, 1);
            res_valid = 1'b1; res_data = 8'(8'h10 + k); res_row = 6'd5; res_col = 6'(k);
            step;
            if (k == 3) res_valid = 1'b0;
            chk("burst_write", {memwrite, address_row, address_col, DIN},
                {1'b1, 6'd5, 6'(k), 8'(8'h10 + k)});
        end
        wait_read(10, 20, ok);
        chk("find_10_20", ok, 1);
        res_valid = 1'b1; res_data = 8'h77; res_row = 6'd9; res_col = 6'd9;
        step;
        res_valid = 1'b0;
        chk("pre_reset", {win_valid, memwrite, win_row, win_col}, {1'b1, 1'b1, 6'd10, 6'd20});
        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", {memread, memwrite, win_valid, busy, done, win_row, win_col,
                              address_row, address_col, DIN}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step;
            if ({done, memwrite, memread, busy} != 4'b0000) bad++;
        end
        chk("after_reset_quiet", bad, 0);
        chk("after_reset_ready", res_ready, 1);
        start = 1'b1; step; start = 1'b0;
        chk("restart_0_0", {memread, address_row, address_col}, {1'b1, 12'h000});
        do_reset;

        // frame C: 3-cycle echo model, start during busy ignored
        rd_n = 0; wr_n = 0; done_n = 0; bad_rd = 0; bad_wr = 0; fin = -1;
        er = 0; ec = 0; busy_prev = 1'b0; kicked = 1'b0;
        start = 1'b1; step; start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (memread) begin
                if (address_row != 6'(er) || address_col != 6'(ec)) bad_rd++;
                pend_q.push_back(((cyc + 3) << 12) | (er << 6) | ec);
                if (ec == 61) begin ec = 0; er++; end else ec++;
                rd_n++;
            end
            if (memwrite) begin
                if (exp_q.size() == 0) bad_wr++;
                else begin
                    e = exp_q.pop_front();
                    if ({address_row, address_col, DIN} != 20'(e)) bad_wr++;
                end
                wr_n++;
            end
            if (done) begin
                done_n++;
                chk("busy_falls_with_done", {busy_prev, busy}, 2'b10);
                if (fin < 0) fin = cyc;
            end
            busy_prev = busy;
            start = (rd_n == 100) && !kicked;
            if (start) kicked = 1'b1;
            res_valid = 1'b0;
            if (pend_q.size() > 0 && (pend_q[0] >> 12) <= cyc && res_ready) begin
                p = pend_q.pop_front();
                r = (p >> 6) & 63;
                c = p & 63;
                d = (r * 4 + c) & 255;
                res_valid = 1'b1; res_row = 6'(r); res_col = 6'(c); res_data = 8'(d);
                exp_q.push_back((r << 14) | (c << 8) | d);
            end
            step;
            if (fin >= 0 && cyc >= fin + 5) break;
        end
        res_valid = 1'b0;
        start = 1'b0;
        chk("echo_reads", rd_n, 3844);
        chk("echo_writes", wr_n, 3844);
        chk("echo_done_pulses", done_n, 1);
        chk("echo_read_seq", bad_rd, 0);
        chk("echo_write_seq", bad_wr, 0);
        chk("echo_left_over", exp_q.size(), 0);
        chk("echo_end_state", dut.state, IDLE);

        // result accepted while idle, not counted in the next frame
        res_valid = 1'b1; res_data = 8'h3C; res_row = 6'd1; res_col = 6'd1;
        step;
        res_valid = 1'b0;
        chk("idle_write", {memwrite, address_row, address_col, DIN}, {1'b1, 6'd1, 6'd1, 8'h3C});
        step;
        start = 1'b1; step; start = 1'b0;
        chk("next_frame_count", dut.wr_cnt, 0);
        chk("next_frame_read", {memread, address_row, address_col}, {1'b1, 12'h000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
